// File: rtl/lpc_frame_ctrl.sv
// LPC frame controller: writes incoming samples into one of two buffer banks and
// hands each completed frame to the analysis datapath. Includes a small register block.
module lpc_frame_ctrl #(
    parameter int FRAME_DEFAULT = 240,
    parameter int MAX_FRAME     = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic        v,
    output logic        buf_we,
    output logic [9:0]  buf_addr,
    output logic [15:0] buf_data,
    output logic        start,
    output logic        proc_bank,
    input  logic        done,
    output logic        frame_ready,
    input  logic [15:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata
);
    localparam int CNT_W = 9;
    localparam int LEN_W = 10;

    localparam logic [15:0] ADDR_FRAME_LEN  = 16'd0;
    localparam logic [15:0] ADDR_CTRL       = 16'd1;
    localparam logic [15:0] ADDR_STATUS     = 16'd2;
    localparam logic [15:0] ADDR_FRAME_CNT  = 16'd3;
    localparam logic [15:0] ADDR_SAMPLE_CNT = 16'd4;

    typedef enum logic {C_IDLE, C_FILL} coll_state_e;
    typedef enum logic {P_IDLE, P_BUSY} proc_state_e;

    coll_state_e      coll_state_q, coll_state_d;
    proc_state_e      proc_state_q, proc_state_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [LEN_W-1:0] len_shadow_q, len_shadow_d;
    logic             enable_q, enable_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             proc_bank_q, proc_bank_d;
    logic             start_q, start_d;
    logic             frame_ready_q, frame_ready_d;
    logic [15:0]      readdata_q, readdata_d;

    logic wr_len, wr_ctrl, len_legal;
    logic sample_acc, boundary, done_acc, proc_free, launch, overrun_set;

    // NOTE: every signal driven in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        wr_len      = write && (address == ADDR_FRAME_LEN);
        wr_ctrl     = write && (address == ADDR_CTRL);
        len_legal   = (writedata != 16'd0) && (writedata <= 16'(MAX_FRAME));
        sample_acc  = v && !rst && (coll_state_q == C_FILL);
        boundary    = sample_acc && ({1'b0, sample_cnt_q} == frame_len_q - LEN_W'(1));
        done_acc    = done && (proc_state_q == P_BUSY);
        // A done in the boundary cycle frees the processor in time for the new frame.
        proc_free   = (proc_state_q == P_IDLE) || done_acc;
        launch      = boundary && proc_free;
        overrun_set = boundary && !proc_free;
    end

    // Collector: sample counter, write bank and frame length.
    always_comb begin
        coll_state_d = coll_state_q;
        sample_cnt_d = sample_cnt_q;
        wr_bank_d    = wr_bank_q;
        frame_len_d  = frame_len_q;
        len_shadow_d = len_shadow_q;

        if (wr_len && len_legal) begin
            len_shadow_d = writedata[LEN_W-1:0];
        end
        if (sample_acc) begin
            sample_cnt_d = boundary ? '0 : sample_cnt_q + CNT_W'(1);
        end
        if (launch) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (boundary || (coll_state_q == C_IDLE)) begin
            frame_len_d = len_shadow_q;
        end

        case (coll_state_q)
            C_IDLE: begin
                if (enable_q) begin
                    coll_state_d = C_FILL;
                end
            end
            C_FILL: begin
                if (!enable_q) begin
                    coll_state_d = C_IDLE;
                    sample_cnt_d = '0;
                end
            end
            default: coll_state_d = C_IDLE;
        endcase
    end

    // Processor handshake: done retires the current frame before a launch claims the datapath.
    always_comb begin
        proc_state_d  = proc_state_q;
        proc_bank_d   = proc_bank_q;
        frame_cnt_d   = frame_cnt_q;
        start_d       = 1'b0;
        frame_ready_d = 1'b0;

        if (done_acc) begin
            proc_state_d  = P_IDLE;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            frame_ready_d = 1'b1;
        end
        if (launch) begin
            proc_state_d = P_BUSY;
            proc_bank_d  = wr_bank_q;
            start_d      = 1'b1;
        end
    end

    // Register block; an overrun in the same cycle as a clear wins.
    always_comb begin
        enable_d   = enable_q;
        overrun_d  = overrun_q;
        readdata_d = readdata_q;

        if (wr_ctrl) begin
            enable_d = writedata[0];
            if (writedata[1]) begin
                overrun_d = 1'b0;
            end
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end

        if (read) begin
            case (address)
                ADDR_FRAME_LEN:  readdata_d = 16'(len_shadow_q);
                ADDR_CTRL:       readdata_d = {15'd0, enable_q};
                ADDR_STATUS:     readdata_d = {12'd0, (coll_state_q == C_FILL), wr_bank_q,
                                               overrun_q, (proc_state_q == P_BUSY)};
                ADDR_FRAME_CNT:  readdata_d = frame_cnt_q;
                ADDR_SAMPLE_CNT: readdata_d = 16'(sample_cnt_q);
                default:         readdata_d = 16'd0;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values and updates together.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_state_q  <= C_IDLE;
            proc_state_q  <= P_IDLE;
            frame_len_q   <= LEN_W'(FRAME_DEFAULT);
            len_shadow_q  <= LEN_W'(FRAME_DEFAULT);
            enable_q      <= 1'b1;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
            sample_cnt_q  <= '0;
            wr_bank_q     <= 1'b0;
            proc_bank_q   <= 1'b0;
            start_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            coll_state_q  <= coll_state_d;
            proc_state_q  <= proc_state_d;
            frame_len_q   <= frame_len_d;
            len_shadow_q  <= len_shadow_d;
            enable_q      <= enable_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            wr_bank_q     <= wr_bank_d;
            proc_bank_q   <= proc_bank_d;
            start_q       <= start_d;
            frame_ready_q <= frame_ready_d;
            readdata_q    <= readdata_d;
        end
    end

    assign buf_we      = sample_acc;
    assign buf_addr    = sample_acc ? {wr_bank_q, sample_cnt_q} : '0;
    assign buf_data    = sample_acc ? x : '0;
    assign start       = start_q;
    assign proc_bank   = proc_bank_q;
    assign frame_ready = frame_ready_q;
    assign readdata    = readdata_q;

endmodule

// File: doc/lpc_frame_ctrl.md
LPC_FRAME_CTRL -- requirements
Module: lpc_frame_ctrl

Interface
REQ-001 Parameter FRAME_DEFAULT, 240, frame length in samples loaded at reset.
REQ-002 Parameter MAX_FRAME, 512, largest legal frame length and depth of each buffer bank.
REQ-003 clk  in  1  system clock (50 MHz); the only clock in the block.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 x  in  16  signed input sample.
REQ-006 v  in  1  sample valid, one-clk pulse per sample (8 kHz rate, already synchronised to clk).
REQ-007 buf_we  out  1  sample buffer write enable.
REQ-008 buf_addr  out  10  buffer address {bank, offset[8:0]}.
REQ-009 buf_data  out  16  sample written to the buffer.
REQ-010 start  out  1  one-clk pulse that launches LPC analysis of a full frame.
REQ-011 proc_bank  out  1  bank the analysis datapath reads, held stable while busy.
REQ-012 done  in  1  one-clk pulse from the datapath when analysis completes.
REQ-013 frame_ready  out  1  one-clk pulse on the cycle after done is accepted.
REQ-014 address  in  16  register address.
REQ-015 read  in  1  register read strobe.
REQ-016 write  in  1  register write strobe.
REQ-017 writedata  in  16  register write data.
REQ-018 readdata  out  16  register read data.

Function
REQ-019 Register map: 0 FRAME_LEN (R/W); 1 CTRL (bit0 ENABLE R/W, bit1 write-1-clears OVERRUN); 2 STATUS (RO: bit0 BUSY, bit1 OVERRUN, bit2 WR_BANK, bit3 COLLECTING); 3 FRAME_CNT (RO, 16-bit, wraps 0xFFFF->0); 4 SAMPLE_CNT (RO). Reads of any other address SHALL return 0.
REQ-020 readdata SHALL be registered and valid on the cycle after read is asserted; it SHALL hold its value otherwise.
REQ-021 A FRAME_LEN write of 0 or greater than MAX_FRAME SHALL be ignored. A legal write SHALL go to a shadow register that becomes the active length only at the next frame boundary or while collection is IDLE.
REQ-022 Collector FSM states: IDLE and FILL. IDLE->FILL when ENABLE=1. FILL->IDLE when ENABLE=0; SAMPLE_CNT SHALL clear on that transition.
REQ-023 In FILL, each v SHALL assert buf_we for exactly that cycle, with buf_addr={WR_BANK, SAMPLE_CNT} and buf_data=x. SAMPLE_CNT SHALL then increment. v in IDLE SHALL be ignored.
REQ-024 Frame boundary: v while SAMPLE_CNT = active length-1. SAMPLE_CNT SHALL wrap to 0.
REQ-025 At a frame boundary with the processor idle, the block SHALL take the following actions in the next cycle: pulse start; set proc_bank to the old WR_BANK; toggle WR_BANK; set BUSY.
REQ-026 At a frame boundary while BUSY, the block SHALL set OVERRUN (sticky), drop the frame, and leave WR_BANK unchanged, so the next frame overwrites the same bank. start SHALL NOT pulse.
REQ-027 Processor FSM states: P_IDLE and P_BUSY. Entry to P_BUSY is by start. P_BUSY->P_IDLE on done, which increments FRAME_CNT and pulses frame_ready. done in P_IDLE SHALL be ignored.
REQ-028 If done and a frame boundary occur in the same cycle, done SHALL be processed first and the new frame SHALL be accepted (no overrun).
REQ-029 Clearing ENABLE SHALL NOT abort an analysis in progress; BUSY SHALL clear only on done.
REQ-030 If OVERRUN is cleared by write and set by an overrun in the same cycle, OVERRUN SHALL remain set.

Reset
REQ-031 On rst, outputs SHALL be set as follows: buf_we=0, start=0, frame_ready=0, buf_addr=0, buf_data=0, proc_bank=0, readdata=0.
REQ-032 On rst, internal state SHALL be set as follows: FRAME_LEN=FRAME_DEFAULT, ENABLE=1, OVERRUN=0, FRAME_CNT=0, SAMPLE_CNT=0, WR_BANK=0, collector IDLE, processor P_IDLE.
REQ-033 rst asserted mid-frame or mid-analysis SHALL discard that work, and no start or frame_ready SHALL follow.

Verification
REQ-034 Reset, then 240 v pulses with x=n -> writes at addr 0..239 with data n. start pulses once, proc_bank=0, STATUS reads 0x000D.
REQ-035 Write FRAME_LEN=16 mid-frame -> the current frame still ends at 240 samples, and the next frame ends after 16.
REQ-036 Withhold done through a second full frame -> no second start, OVERRUN=1, WR_BANK stays 1. Write CTRL=0x0003 -> OVERRUN=0.
REQ-037 done on the same cycle as a frame boundary -> start pulses, no OVERRUN, FRAME_CNT increments by 1.
REQ-038 Writes of FRAME_LEN 0 and 513 -> FRAME_LEN readback unchanged. Read of address 7 -> 0.
REQ-039 rst at sample 100 -> SAMPLE_CNT=0 and the next frame completes after 240 samples into bank 0.
